// File: rtl/pipelined_adder_result_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_adder_result_buffer_if
// Description : Issue credit, adder result capture and consumer handshake
//               signals of the pipelined adder result buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipelined_adder_result_buffer_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
);
    localparam int c_occ_w = $clog2(DEPTH) + 1;

    logic               issue_valid;
    logic               issue_ready;
    logic [WIDTH-1:0]   sum_in;
    logic               cout_in;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_sum;
    logic               out_cout;
    logic [c_occ_w-1:0] occupancy;
    logic               err;

    // Operand source, adder outputs and consumer side
    modport master (
        output issue_valid, sum_in, cout_in, out_ready,
        input  issue_ready, out_valid, out_sum, out_cout, occupancy, err
    );

    // Result buffer side
    modport slave (
        input  issue_valid, sum_in, cout_in, out_ready,
        output issue_ready, out_valid, out_sum, out_cout, occupancy, err
    );
endinterface
`default_nettype wire

// File: rtl/pipelined_adder_result_buffer.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_adder_result_buffer
// Description : Tracks live adder issue slots, captures each {c,s} result
//               LATENCY cycles after issue into a FIFO, and grants issue
//               credits only when FIFO space is guaranteed for the result.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_adder_result_buffer #(
    parameter int WIDTH   = 4,
    parameter int LATENCY = 4,
    parameter int DEPTH   = 8
) (
    input  wire logic                      clk,
    input  wire logic                      rst_n,
    pipelined_adder_result_buffer_if.slave bus
);
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_occ_w = c_ptr_w + 1;
    localparam int c_inf_w = $clog2(LATENCY + 1);
    localparam int c_sum_w = $clog2(LATENCY + DEPTH + 1);
    localparam logic [c_occ_w-1:0] c_depth = c_occ_w'(DEPTH);

    logic [LATENCY-1:0] r_vp;
    logic [c_inf_w-1:0] r_inflight;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_occ_w-1:0] r_occupancy;
    logic               r_err;
    logic [WIDTH:0]     r_mem [DEPTH];

    logic               w_issue_ready;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_write;
    logic               w_out_valid;
    logic [c_sum_w-1:0] w_credit_sum;

    // Credit and FIFO control, derived only from registered state plus strobes
    always_comb begin
        w_credit_sum  = c_sum_w'(r_inflight) + c_sum_w'(r_occupancy);
        // A pop this cycle is deliberately not credited until the next cycle
        w_issue_ready = w_credit_sum < c_sum_w'(DEPTH);
        w_accept      = bus.issue_valid && w_issue_ready;
        w_push        = r_vp[LATENCY-1];
        w_out_valid   = (r_occupancy != '0);
        w_pop         = w_out_valid && bus.out_ready;
        w_full        = (r_occupancy == c_depth);
        // A full FIFO can still take a push when the head leaves in the same cycle
        w_write       = w_push && (!w_full || w_pop);
    end

    assign bus.issue_ready = w_issue_ready;
    assign bus.out_valid   = w_out_valid;
    assign bus.occupancy   = r_occupancy;
    assign bus.err         = r_err;
    // Stale memory contents are masked so the outputs read zero while empty
    assign bus.out_sum     = w_out_valid ? r_mem[r_rd_ptr][WIDTH-1:0] : '0;
    assign bus.out_cout    = w_out_valid ? r_mem[r_rd_ptr][WIDTH]     : 1'b0;

    // Valid pipe mirrors the adder pipeline: marks slots that carry real operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vp <= '0;
        end else begin
            r_vp[0] <= w_accept;
            for (int i = 1; i < LATENCY; i++) begin
                r_vp[i] <= r_vp[i-1];
            end
        end
    end

    // In-flight count equals the number of ones in the valid pipe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= '0;
        end else begin
            case ({w_accept, w_push})
                2'b10:   r_inflight <= r_inflight + c_inf_w'(1);
                2'b01:   r_inflight <= r_inflight - c_inf_w'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_occupancy <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_write, w_pop})
                2'b10:   r_occupancy <= r_occupancy + c_occ_w'(1);
                2'b01:   r_occupancy <= r_occupancy - c_occ_w'(1);
                default: r_occupancy <= r_occupancy;
            endcase
            if (w_push && w_full && !w_pop) begin
                r_err <= 1'b1;
            end
        end
    end

    // Result storage; contents need no reset because occupancy gates visibility
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= {bus.cout_in, bus.sum_in};
        end
    end

    // Overflow cannot occur while issues are gated by the credit rule
    assert property (@(posedge clk) disable iff (!rst_n) !(w_push && w_full && !w_pop));

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder_result_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_adder_result_buffer
// Description : Self-checking bench with a behavioural pipelined adder and a
//               result scoreboard for pipelined_adder_result_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_adder_result_buffer;
    localparam int c_width   = 4;
    localparam int c_latency = 4;
    localparam int c_depth   = 8;

    logic clk;
    logic rst_n;
    logic [c_width-1:0] op_a;
    logic [c_width-1:0] op_b;
    logic               op_cin;

    int test_cnt;
    int fail_cnt;
    int pop_cnt;
    logic [c_width:0] exp_q [$];

    pipelined_adder_result_buffer_if #(.WIDTH(c_width), .DEPTH(c_depth)) bus ();

    pipelined_adder_result_buffer #(
        .WIDTH   (c_width),
        .LATENCY (c_latency),
        .DEPTH   (c_depth)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [c_width:0] add_ref(input logic [c_width-1:0] a,
                                                 input logic [c_width-1:0] b,
                                                 input logic c);
        return {1'b0, a} + {1'b0, b} + (c_width+1)'(c);
    endfunction

    // Behavioural adder: operands seen in cycle t appear on s/c in cycle t+LATENCY
    logic [c_width:0] pipe [c_latency];
    always_ff @(posedge clk) begin
        pipe[0] <= add_ref(op_a, op_b, op_cin);
        for (int i = 1; i < c_latency; i++) begin
            pipe[i] <= pipe[i-1];
        end
    end
    assign bus.sum_in  = pipe[c_latency-1][c_width-1:0];
    assign bus.cout_in = pipe[c_latency-1][c_width];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        test_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; idle slots get random operands
    task automatic tick();
        @(posedge clk);
        #1;
        bus.issue_valid = 1'b0;
        op_a   = c_width'($urandom);
        op_b   = c_width'($urandom);
        op_cin = 1'($urandom);
    endtask

    task automatic issue(input logic [c_width-1:0] a, input logic [c_width-1:0] b, input logic c);
        bus.issue_valid = 1'b1;
        op_a   = a;
        op_b   = b;
        op_cin = c;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard: record accepted issues, compare every completed pop
    task automatic monitor();
        logic [c_width:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.out_valid && bus.out_ready) begin
                    pop_cnt++;
                    check("sb_pop_nonempty", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("sb_data", 32'({bus.out_cout, bus.out_sum}), 32'(e));
                    end
                end
                if (bus.issue_valid && bus.issue_ready) begin
                    exp_q.push_back(add_ref(op_a, op_b, op_cin));
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int acc;
        int p0;
        int n_pp;
        logic [c_width:0] b2b_exp [3];

        test_cnt = 0;
        fail_cnt = 0;
        pop_cnt  = 0;
        rst_n           = 1'b0;
        bus.issue_valid = 1'b0;
        bus.out_ready   = 1'b0;
        op_a   = '0;
        op_b   = '0;
        op_cin = 1'b0;
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) tick();
        check("rst_issue_ready", 32'(bus.issue_ready), 32'd1);
        check("rst_out_valid",   32'(bus.out_valid),   32'd0);
        check("rst_occupancy",   32'(bus.occupancy),   32'd0);
        check("rst_err",         32'(bus.err),         32'd0);
        check("rst_out_data",    32'({bus.out_cout, bus.out_sum}), 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Single issue: latency, value, hold under backpressure
        issue(4'd4, 4'd5, 1'b1);
        tick();
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("single_latency", 32'(lat), 32'(c_latency + 1));
        check("single_sum",     32'(bus.out_sum),   32'b1010);
        check("single_cout",    32'(bus.out_cout),  32'd0);
        check("single_occ",     32'(bus.occupancy), 32'd1);
        repeat (3) tick();
        check("single_hold_sum", 32'(bus.out_sum),   32'b1010);
        check("single_hold_occ", 32'(bus.occupancy), 32'd1);
        bus.out_ready = 1'b1;
        tick();
        check("single_popped_occ", 32'(bus.occupancy), 32'd0);
        check("single_empty_sum",  32'({bus.out_cout, bus.out_sum}), 32'd0);
        wait_drain("single_drain");

        // Back-to-back issues with consumer always ready
        b2b_exp[0] = 5'b01010;
        b2b_exp[1] = 5'b10011;
        b2b_exp[2] = 5'b10001;
        tick();
        check("b2b_rdy0", 32'(bus.issue_ready), 32'd1);
        issue(4'd4, 4'd5, 1'b1);
        tick();
        check("b2b_rdy1", 32'(bus.issue_ready), 32'd1);
        issue(4'd15, 4'd4, 1'b0);
        tick();
        check("b2b_rdy2", 32'(bus.issue_ready), 32'd1);
        issue(4'd8, 4'd8, 1'b1);
        tick();
        repeat (c_latency - 2) tick();
        for (int k = 0; k < 3; k++) begin
            check("b2b_valid", 32'(bus.out_valid), 32'd1);
            check("b2b_result", 32'({bus.out_cout, bus.out_sum}), 32'(b2b_exp[k]));
            tick();
        end
        check("b2b_after_valid", 32'(bus.out_valid), 32'd0);
        wait_drain("b2b_drain");

        // Backpressure: exactly DEPTH issues accepted, then drain in order
        bus.out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < c_depth + c_latency + 4; i++) begin
            tick();
            if (bus.issue_ready) acc++;
            issue(c_width'($urandom), c_width'($urandom), 1'($urandom));
        end
        tick();
        check("bp_accepted", 32'(acc), 32'(c_depth));
        repeat (c_latency + 2) tick();
        check("bp_occ_full",  32'(bus.occupancy),   32'(c_depth));
        check("bp_err",       32'(bus.err),         32'd0);
        check("bp_rdy_low",   32'(bus.issue_ready), 32'd0);
        bus.out_ready = 1'b1;
        #1;
        check("bp_rdy_same_cycle", 32'(bus.issue_ready), 32'd0);
        tick();
        check("bp_rdy_after_pop",  32'(bus.issue_ready), 32'd1);
        check("bp_occ_after_pop",  32'(bus.occupancy),   32'(c_depth - 1));
        wait_drain("bp_drain");

        // Simultaneous push and pop at occupancy 1 across pointer wrap
        bus.out_ready = 1'b0;
        tick();
        issue(c_width'($urandom), c_width'($urandom), 1'($urandom));
        lat = 0;
        do begin
            tick();
            lat++;
        end while (bus.occupancy != 1 && lat < 20);
        check("pp_start_occ", 32'(bus.occupancy), 32'd1);
        p0 = pop_cnt;
        n_pp = 2 * c_depth + c_latency + 2;
        for (int k = 0; k < n_pp; k++) begin
            if (k > 0) tick();
            check("pp_occ", 32'(bus.occupancy), 32'd1);
            check("pp_rdy", 32'(bus.issue_ready), 32'd1);
            issue(c_width'($urandom), c_width'($urandom), 1'($urandom));
            if (k >= c_latency) bus.out_ready = 1'b1;
        end
        tick();
        wait_drain("pp_drain");
        check("pp_pop_count", 32'(pop_cnt - p0), 32'(n_pp + 1));

        // Idle slots: garbage on the adder outputs is never captured
        bus.out_ready = 1'b1;
        p0 = pop_cnt;
        tick();
        issue(4'd3, 4'd9, 1'b0);
        tick();
        tick();
        issue(4'd7, 4'd7, 1'b1);
        repeat (c_latency + 4) tick();
        check("idle_pop_count", 32'(pop_cnt - p0), 32'd2);
        check("idle_q_empty",   32'(exp_q.size()), 32'd0);

        // Reset with three results in flight and two buffered
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            issue(c_width'($urandom), c_width'($urandom), 1'($urandom));
        end
        tick();
        repeat (c_latency - 3) tick();
        check("rstm_pre_occ", 32'(bus.occupancy), 32'd2);
        rst_n = 1'b0;
        #1;
        check("rstm_out_valid", 32'(bus.out_valid),   32'd0);
        check("rstm_occ",       32'(bus.occupancy),   32'd0);
        check("rstm_rdy",       32'(bus.issue_ready), 32'd1);
        check("rstm_err",       32'(bus.err),         32'd0);
        check("rstm_data",      32'({bus.out_cout, bus.out_sum}), 32'd0);
        exp_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        p0 = pop_cnt;
        for (int i = 0; i < c_latency + 4; i++) begin
            tick();
            check("rstm_no_stale", 32'(bus.out_valid), 32'd0);
        end
        check("rstm_pop_count", 32'(pop_cnt - p0), 32'd0);
        check("rstm_rdy_after", 32'(bus.issue_ready), 32'd1);
        check("final_err",      32'(bus.err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
`default_nettype wire
